// File: rtl/sm2_pkg.sv
// Shared SM2 constants and the inverter state type.
package sm2_pkg;

  localparam int unsigned SM2_WIDTH = 256;

  localparam logic [255:0] SM2_P =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;

  localparam logic [255:0] SM2_P_MINUS_2 = SM2_P - 256'd2;

  typedef enum logic [2:0] {
    INV_IDLE,
    INV_SQR,
    INV_SQR_W,
    INV_MUL,
    INV_MUL_W,
    INV_FIN
  } inv_state_e;

endpackage

// File: rtl/mod_inv_p.sv
// Fermat modular inverse x^(P-2) mod P, sequencing an external a*b mod P multiplier.
// Optional zero-operand short cut and err flag: define MOD_INV_ZERO_DET_EN.
module mod_inv_p
  import sm2_pkg::*;
#(
  parameter int unsigned      WIDTH = SM2_WIDTH,
  parameter logic [WIDTH-1:0] P     = SM2_P
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] x_inv,
  output logic             err,
  output logic             mul_req,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_res,
  input  logic             mul_ack
);

  localparam logic [WIDTH-1:0] E       = P - WIDTH'(2);
  localparam logic [8:0]       IDX_TOP = 9'(WIDTH - 2);

  inv_state_e       r_state;
  inv_state_e       w_next;
  logic [8:0]       r_idx;
  logic [WIDTH-1:0] r_r;
  logic [WIDTH-1:0] r_base;
  logic [WIDTH-1:0] r_x_inv;
  logic             r_busy;
  logic             r_done;
  logic             w_ebit;
  logic             w_last;
  logic             w_zero;
  logic             w_mul_req;

  assign w_ebit = E[r_idx[7:0]];
  assign w_last = (r_idx == '0);

`ifdef MOD_INV_ZERO_DET_EN
  assign w_zero = (x == '0);
`else
  assign w_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INV_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_mul_req = 1'b0;
    case (r_state)
      INV_IDLE: begin
        // Zero operand skips the exponentiation and goes straight to FIN with r=0
        if (start) w_next = w_zero ? INV_FIN : INV_SQR;
      end
      INV_SQR: begin
        w_mul_req = 1'b1;
        w_next    = INV_SQR_W;
      end
      INV_SQR_W: begin
        if (mul_ack) begin
          if (w_ebit)      w_next = INV_MUL;
          else if (w_last) w_next = INV_FIN;
          else             w_next = INV_SQR;
        end
      end
      INV_MUL: begin
        w_mul_req = 1'b1;
        w_next    = INV_MUL_W;
      end
      INV_MUL_W: begin
        if (mul_ack) w_next = w_last ? INV_FIN : INV_SQR;
      end
      INV_FIN:  w_next = INV_IDLE;
      default:  w_next = INV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= IDX_TOP;
      r_r     <= '0;
      r_base  <= '0;
      r_x_inv <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        INV_IDLE: begin
          if (start) begin
            r_r    <= x;
            r_base <= x;
            r_idx  <= IDX_TOP;
            r_busy <= 1'b1;
          end
        end
        INV_SQR_W: begin
          if (mul_ack) begin
            r_r <= mul_res;
            // A set exponent bit keeps the index for the following multiply
            if (!w_ebit && !w_last) r_idx <= r_idx - 9'd1;
          end
        end
        INV_MUL_W: begin
          if (mul_ack) begin
            r_r <= mul_res;
            if (!w_last) r_idx <= r_idx - 9'd1;
          end
        end
        INV_FIN: begin
          r_x_inv <= r_r;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef MOD_INV_ZERO_DET_EN
  logic r_err;

  // A valid nonzero operand never inverts to zero, so r==0 at FIN marks a zero operand
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_err <= 1'b0;
    else if (r_state == INV_FIN) r_err <= (r_r == '0);
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign x_inv   = r_x_inv;
  assign mul_req = w_mul_req;
  assign mul_a   = r_r;
  assign mul_b   = (r_state == INV_MUL || r_state == INV_MUL_W) ? r_base : r_r;

endmodule

// File: tb/tb_mod_inv_p.sv
// Self-checking bench for mod_inv_p with a latency-programmable multiplier model.
module tb_mod_inv_p;

  localparam int unsigned W = 256;
  localparam logic [W-1:0] PM =
    256'hFFFFFFFE_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_FFFFFFFF_FFFFFFFF;
  localparam logic [W-1:0] INV2 =
    256'h7FFFFFFF_7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_80000000_80000000_00000000;
  localparam int unsigned NTRANS = 476;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] x;
  logic         busy;
  logic         done;
  logic [W-1:0] x_inv;
  logic         err;
  logic         mul_req;
  logic [W-1:0] mul_a;
  logic [W-1:0] mul_b;
  logic [W-1:0] mul_res;
  logic         mul_ack;

  mod_inv_p #(.WIDTH(W), .P(PM)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .x_inv   (x_inv),
    .err     (err),
    .mul_req (mul_req),
    .mul_a   (mul_a),
    .mul_b   (mul_b),
    .mul_res (mul_res),
    .mul_ack (mul_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    p = p % {{W{1'b0}}, PM};
    return p[W-1:0];
  endfunction

  // Multiplier model: ack exactly L cycles after the request cycle, L drawn per transaction
  logic         m_ack = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         spur_ack = 1'b0;
  logic [W-1:0] spur_res = '0;
  logic         pend = 1'b0;
  int unsigned  cnt = 0;
  logic [W-1:0] m_val = '0;
  int unsigned  nreq = 0;
  int unsigned  nviol = 0;
  int unsigned  lat_lo = 1;
  int unsigned  lat_hi = 1;

  assign mul_ack = m_ack | spur_ack;
  assign mul_res = spur_ack ? spur_res : m_res;

  always @(posedge clk) begin : mul_model
    int unsigned l;
    m_ack <= 1'b0;
    if (mul_req) nreq <= nreq + 1;
    if (pend) begin
      if (mul_req) nviol <= nviol + 1;
      if (cnt == 1) begin
        m_ack <= 1'b1;
        m_res <= m_val;
        pend  <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (mul_req) begin
      l = $urandom_range(lat_hi, lat_lo);
      if (l == 1) begin
        m_ack <= 1'b1;
        m_res <= mulmod(mul_a, mul_b);
      end else begin
        m_val <= mulmod(mul_a, mul_b);
        pend  <= 1'b1;
        cnt   <= l - 1;
      end
    end
  end

  task automatic run_inv(input logic [W-1:0] xv, output logic [W-1:0] inv, output logic e,
                         output int unsigned lat, output int unsigned reqs,
                         output logic b1, output logic ok);
    int unsigned c0, r0, lim;
    @(negedge clk);
    x = xv;
    start = 1'b1;
    c0 = cyc;
    r0 = nreq;
    @(negedge clk);
    start = 1'b0;
    b1 = busy;
    lim = NTRANS * (lat_hi + 1) + 50;
    while (!done && (cyc - c0) < lim) @(negedge clk);
    ok   = done;
    lat  = cyc - c0;
    inv  = x_inv;
    e    = err;
    reqs = nreq - r0;
  endtask

  function automatic logic [W-1:0] rand_x();
    logic [W-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    v = v % PM;
    if (v == '0) v = 1;
    return v;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    x = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({busy, done, err, mul_req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, err, mul_req});
    end
    n_chk++;
    if (x_inv !== '0) begin
      n_fail++;
      $display("FAIL reset_x_inv: got %h expected 0", x_inv);
    end
    n_chk++;
    if ((mul_a | mul_b) !== '0) begin
      n_fail++;
      $display("FAIL reset_mul_ops: got a=%h b=%h expected 0", mul_a, mul_b);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one();
    logic [W-1:0] inv;
    logic e, b1, ok;
    int unsigned lat, reqs;
    lat_lo = 1;
    lat_hi = 1;
    run_inv(1, inv, e, lat, reqs, b1, ok);
    n_chk++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL one_done: got %b expected 1", ok); end
    n_chk++;
    if (inv !== W'(1)) begin n_fail++; $display("FAIL one_inv: got %h expected 1", inv); end
    n_chk++;
    if (reqs != NTRANS) begin n_fail++; $display("FAIL one_reqs: got %0d expected %0d", reqs, NTRANS); end
    n_chk++;
    if (lat != 954) begin n_fail++; $display("FAIL one_latency: got %0d expected 954", lat); end
    n_chk++;
    if (b1 !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL one_busy: got first=%b at_done=%b expected 1 0", b1, busy);
    end
    n_chk++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL one_err: got %b expected 0", e); end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || x_inv !== W'(1)) begin
      n_fail++;
      $display("FAIL one_done_pulse: got done=%b x_inv=%h expected 0 1", done, x_inv);
    end
  endtask

  task automatic test_known();
    logic [W-1:0] inv;
    logic e, b1, ok;
    int unsigned lat, reqs;
    lat_lo = 1;
    lat_hi = 3;
    run_inv(2, inv, e, lat, reqs, b1, ok);
    n_chk++;
    if (ok !== 1'b1 || inv !== INV2) begin
      n_fail++;
      $display("FAIL inv_two: got ok=%b %h expected %h", ok, inv, INV2);
    end
    run_inv(PM - 1, inv, e, lat, reqs, b1, ok);
    n_chk++;
    if (ok !== 1'b1 || inv !== PM - 1) begin
      n_fail++;
      $display("FAIL inv_pm1: got ok=%b %h expected %h", ok, inv, PM - 1);
    end
  endtask

  task automatic test_zero();
    logic [W-1:0] inv;
    logic e, b1, ok;
    int unsigned lat, reqs;
    lat_lo = 1;
    lat_hi = 1;
    run_inv('0, inv, e, lat, reqs, b1, ok);
    n_chk++;
    if (ok !== 1'b1 || inv !== '0) begin
      n_fail++;
      $display("FAIL zero_inv: got ok=%b %h expected 0", ok, inv);
    end
`ifdef MOD_INV_ZERO_DET_EN
    n_chk++;
    if (e !== 1'b1 || reqs != 0 || lat != 2) begin
      n_fail++;
      $display("FAIL zero_det: got err=%b reqs=%0d lat=%0d expected 1 0 2", e, reqs, lat);
    end
    n_chk++;
    if (b1 !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy: got first=%b at_done=%b expected 1 0", b1, busy);
    end
`else
    n_chk++;
    if (e !== 1'b0 || reqs != NTRANS) begin
      n_fail++;
      $display("FAIL zero_full: got err=%b reqs=%0d expected 0 %0d", e, reqs, NTRANS);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int unsigned c0, ndone, lim;
    logic [W-1:0] inv;
    lat_lo = 1;
    lat_hi = 2;
    ndone = 0;
    inv = '0;
    @(negedge clk);
    x = 3;
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    n_chk++;
    if (mul_req !== 1'b1) begin n_fail++; $display("FAIL b2b_first_req: got %b expected 1", mul_req); end
    spur_ack = 1'b1;
    spur_res = rand_x();
    @(negedge clk);
    spur_ack = 1'b0;
    repeat (5) @(negedge clk);
    x = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lim = NTRANS * (lat_hi + 1) + 80;
    while ((cyc - c0) < lim) begin
      if (done) begin
        ndone++;
        inv = x_inv;
      end
      @(negedge clk);
    end
    n_chk++;
    if (ndone != 1) begin n_fail++; $display("FAIL b2b_done_count: got %0d expected 1", ndone); end
    n_chk++;
    if (mulmod(inv, 3) !== W'(1)) begin
      n_fail++;
      $display("FAIL b2b_inv3: got 3*%h mod P = %h expected 1", inv, mulmod(inv, 3));
    end
  endtask

  task automatic test_random();
    logic [W-1:0] xv, inv;
    logic e, b1, ok;
    int unsigned lat, reqs;
    for (int n = 0; n < 21; n++) begin
      lat_lo = 1;
      lat_hi = (n == 20) ? 20 : 4;
      xv = rand_x();
      run_inv(xv, inv, e, lat, reqs, b1, ok);
      n_chk++;
      if (ok !== 1'b1 || mulmod(xv, inv) !== W'(1)) begin
        n_fail++;
        $display("FAIL rand_inv[%0d]: got ok=%b x=%h inv=%h expected x*inv=1", n, ok, xv, inv);
      end
      n_chk++;
      if (reqs != NTRANS || e !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_reqs[%0d]: got reqs=%0d err=%b expected %0d 0", n, reqs, e, NTRANS);
      end
    end
  endtask

  task automatic test_reset_mid();
    int unsigned r0, c0, nd, nr;
    logic [W-1:0] inv;
    logic e, b1, ok;
    int unsigned lat, reqs;
    lat_lo = 5;
    lat_hi = 5;
    @(negedge clk);
    x = 3;
    start = 1'b1;
    r0 = nreq;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while ((nreq - r0) < 100 && (cyc - c0) < 2000) @(negedge clk);
    n_chk++;
    if ((nreq - r0) != 100) begin n_fail++; $display("FAIL mid_reach100: got %0d expected 100", nreq - r0); end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, err, mul_req} !== 4'b0000 || x_inv !== '0 || (mul_a | mul_b) !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_vals: got ctrl=%b x_inv=%h a=%h b=%h expected all 0",
               {busy, done, err, mul_req}, x_inv, mul_a, mul_b);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    nr = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
      if (mul_req || busy) nr++;
    end
    n_chk++;
    if (nd != 0 || nr != 0 || x_inv !== '0) begin
      n_fail++;
      $display("FAIL mid_post_release: got done=%0d active=%0d x_inv=%h expected 0 0 0", nd, nr, x_inv);
    end
    lat_lo = 1;
    lat_hi = 2;
    run_inv(3, inv, e, lat, reqs, b1, ok);
    n_chk++;
    if (ok !== 1'b1 || mulmod(inv, 3) !== W'(1) || reqs != NTRANS) begin
      n_fail++;
      $display("FAIL mid_rerun: got ok=%b inv=%h reqs=%0d expected 3*inv=1 %0d", ok, inv, reqs, NTRANS);
    end
  endtask

  initial begin
    test_reset();
    test_one();
    test_known();
    test_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    n_chk++;
    if (nviol != 0) begin n_fail++; $display("FAIL req_while_pending: got %0d expected 0", nviol); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
